cdb_arbiter: RTL and testbench
==============================

# cdb_arbiter

Round-robin arbiter and output register for the common data bus (CDB) of the out-of-order core. Up to NUM_REQ functional units present results with valid/ready handshakes. The block accepts at most one result per cycle, registers it and broadcasts it to the reservation stations and ROB. The winner index is carried on cdb_src so consumers can steer and demux per source.

## Interface
- BIT_WIDTH, 8: payload width of each result (tag and value packed); must be ≥1.
- NUM_REQ, 4: number of requesting functional units; must be a power of 2, ≥2.
- clk  input  1  sole clock; all state updates on its rising edge.
- reset  input  1  asynchronous, active-high; clears all state immediately.
- flush  input  1  synchronous pipeline flush (mispredict); active-high.
- req_valid  input  [NUM_REQ-1:0]  per-unit result valid.
- req_data  input  NUM_REQ x [BIT_WIDTH-1:0] (unpacked array)  per-unit result payload.
- req_ready  output  [NUM_REQ-1:0]  per-unit accept, combinational; at most one bit set.
- cdb_ready  input  1  downstream can consume the current broadcast.
- cdb_valid  output  1  registered broadcast valid.
- cdb_data  output  [BIT_WIDTH-1:0]  registered broadcast payload.
- cdb_src  output  [$clog2(NUM_REQ)-1:0]  index of the unit that produced cdb_data.

## Operation
- State consists of:
  - the output register: cdb_valid, cdb_data, cdb_src;
  - rr_ptr, $clog2(NUM_REQ) bits, the highest-priority requester for the next grant.
- The output slot is free when `load = !cdb_valid || cdb_ready`.
- Grant is computed combinationally:
  - It applies when `load && !flush && |req_valid`.
  - The winner g is the first index i with req_valid[i] set, scanning cyclically rr_ptr, rr_ptr+1, …, wrapping mod NUM_REQ.
  - req_ready[g]=1; all other req_ready bits are 0.
  - When no grant applies, req_ready is all 0.
- On a grant, at the clock edge:
  - cdb_valid<=1, cdb_data<=req_data[g], cdb_src<=g.
  - rr_ptr<=(g+1) mod NUM_REQ, with natural wrap because NUM_REQ is a power of 2.
- When `load && !flush && !(|req_valid)`: cdb_valid<=0. cdb_data and cdb_src hold their values (don't-care). rr_ptr holds.
- When `!load && !flush`: the output register and rr_ptr hold. This is a backpressure stall.
- When flush=1:
  - cdb_valid<=0 and req_ready all 0, regardless of cdb_ready or req_valid.
  - rr_ptr holds.
  - Flush beats a simultaneous request; no result is accepted that cycle.
- Requester contract:
  - Once req_valid[i] is asserted, the unit holds req_valid[i] and req_data[i] stable until req_ready[i]=1.
  - req_valid must not depend on req_ready.
- Reset (asynchronous): cdb_valid=0, cdb_data=0, cdb_src=0, rr_ptr=0. req_ready is all 0 while reset is asserted.
- A reset during a stall discards the held broadcast. The first grant after reset deassertion starts scanning at index 0.

## Timing
- Accept-to-broadcast latency is 1 cycle. A result accepted in cycle N has cdb_valid=1 in cycle N+1.
- Throughput is 1 result/cycle when cdb_ready is held 1.
- With cdb_ready=1 and a broadcast present, a new result is accepted in the same cycle the old one is consumed (back-to-back, no bubble).
- With cdb_ready=0 and cdb_valid=1, no acceptance occurs and the outputs are stable.
- Fairness: a continuously asserted requester is granted within NUM_REQ consecutive grant cycles.
- req_ready is combinational from req_valid, rr_ptr, cdb_valid, cdb_ready and flush. There is no combinational path from req_data to any output.

## Test plan
NUM_REQ=4, BIT_WIDTH=8 throughout.

- **Reset:** assert reset mid-cycle with cdb_valid=1 → cdb_valid=0, cdb_src=0, cdb_data=0 immediately. After release, req_valid=4'b1000 → grant to 3 and cdb_src=3 next cycle.
- **Round-robin rotation:** req_valid=4'b1111 held, cdb_ready=1, req_data[i]=8'h10+i → cdb_src sequence 0,1,2,3,0 on consecutive cycles. cdb_data follows 8'h10,8'h11,8'h12,8'h13,8'h10.
- **Skip and wrap:** rr_ptr=3 (after granting 2), req_valid=4'b0011 → grant 0, then rr_ptr=1. Next cycle grant 1.
- **Backpressure:** cdb_valid=1 with cdb_src=1, cdb_ready=0 for 3 cycles, req_valid=4'b0100 → req_ready=0 all 3 cycles, outputs stable. When cdb_ready=1, req_ready[2]=1 that cycle and cdb_src=2 next cycle.
- **Flush vs request:** flush=1 with req_valid=4'b0001, cdb_ready=0, cdb_valid=1 → req_ready=0 and cdb_valid=0 next cycle, rr_ptr unchanged. The following cycle unit 0 is granted.
- **Idle drain:** single grant, then req_valid=0, cdb_ready=1 → cdb_valid pulses for exactly 1 cycle.

Source files
------------

// File: rtl/cdb_arbiter.sv
// cdb_arbiter: round-robin arbiter plus output register for the common data
// bus. At most one functional-unit result is accepted per cycle, registered,
// and broadcast with the index of the unit that produced it.
//
// Ports:
//   clk        sole clock, rising edge
//   reset      asynchronous active-high reset
//   flush      synchronous flush; drops the broadcast and blocks acceptance
//   req_valid  per-unit result valid            [NUM_REQ-1:0]
//   req_data   per-unit result payload          NUM_REQ x [BIT_WIDTH-1:0]
//   req_ready  per-unit accept (comb, one-hot or zero)
//   cdb_ready  downstream consumes the current broadcast
//   cdb_valid  registered broadcast valid
//   cdb_data   registered broadcast payload
//   cdb_src    index of the unit that produced cdb_data
module cdb_arbiter #(
    parameter int BIT_WIDTH = 8,
    parameter int NUM_REQ   = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       flush,
    input  logic [NUM_REQ-1:0]         req_valid,
    input  logic [BIT_WIDTH-1:0]       req_data [NUM_REQ],
    output logic [NUM_REQ-1:0]         req_ready,
    input  logic                       cdb_ready,
    output logic                       cdb_valid,
    output logic [BIT_WIDTH-1:0]       cdb_data,
    output logic [$clog2(NUM_REQ)-1:0] cdb_src
);
    localparam int IW = $clog2(NUM_REQ);

    logic [IW-1:0] rr_ptr;
    logic [IW-1:0] win;
    logic [IW-1:0] idx;
    logic          found;
    logic          load;
    logic          grant;

    // Output slot is free when empty or being consumed this cycle.
    assign load = !cdb_valid || cdb_ready;

    // Cyclic scan starting at rr_ptr; IW-bit index arithmetic wraps naturally
    // because NUM_REQ is a power of two.
    always_comb begin
        found = 1'b0;
        win   = '0;
        idx   = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = rr_ptr + IW'(k);
            if (!found && req_valid[idx]) begin
                found = 1'b1;
                win   = idx;
            end
        end
    end

    // reset is folded in so no unit sees an accept while reset is held.
    assign grant     = load && !flush && !reset && found;
    assign req_ready = grant ? (NUM_REQ'(1) << win) : '0;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cdb_valid <= 1'b0;
            cdb_data  <= '0;
            cdb_src   <= '0;
            rr_ptr    <= '0;
        end else if (flush) begin
            cdb_valid <= 1'b0;
        end else if (load) begin
            if (found) begin
                cdb_valid <= 1'b1;
                cdb_data  <= req_data[win];
                cdb_src   <= win;
                rr_ptr    <= win + IW'(1);
            end else begin
                cdb_valid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_cdb_arbiter.sv
module tb_cdb_arbiter;
    logic       clk = 1'b0;
    logic       reset;
    logic       flush;
    logic [3:0] req_valid;
    logic [7:0] req_data [4];
    logic [3:0] req_ready;
    logic       cdb_ready;
    logic       cdb_valid;
    logic [7:0] cdb_data;
    logic [1:0] cdb_src;

    int total = 0;
    int bad   = 0;

    cdb_arbiter #(.BIT_WIDTH(8), .NUM_REQ(4)) dut (
        .clk(clk), .reset(reset), .flush(flush),
        .req_valid(req_valid), .req_data(req_data), .req_ready(req_ready),
        .cdb_ready(cdb_ready), .cdb_valid(cdb_valid), .cdb_data(cdb_data),
        .cdb_src(cdb_src)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge, then step off it before driving or sampling.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_out(input string tag, input logic v, input logic [1:0] s, input logic [7:0] d);
        chk({tag, ".valid"}, 32'(cdb_valid), 32'(v));
        chk({tag, ".src"},   32'(cdb_src),   32'(s));
        chk({tag, ".data"},  32'(cdb_data),  32'(d));
    endtask

    initial begin
        reset = 1'b1; flush = 1'b0; cdb_ready = 1'b1; req_valid = 4'b1111;
        for (int i = 0; i < 4; i++) req_data[i] = 8'h10 + 8'(i);
        #1;
        // Held in reset: no accepts even with requests pending.
        chk("rst_ready", 32'(req_ready), 32'h0);
        chk_out("rst", 1'b0, 2'd0, 8'h00);
        tick();
        reset = 1'b0;
        #1;

        // Round-robin rotation with all four requesting.
        chk("rot_ready0", 32'(req_ready), 32'b0001);
        tick(); chk_out("rot0", 1'b1, 2'd0, 8'h10); chk("rot_ready1", 32'(req_ready), 32'b0010);
        tick(); chk_out("rot1", 1'b1, 2'd1, 8'h11); chk("rot_ready2", 32'(req_ready), 32'b0100);
        tick(); chk_out("rot2", 1'b1, 2'd2, 8'h12); chk("rot_ready3", 32'(req_ready), 32'b1000);
        tick(); chk_out("rot3", 1'b1, 2'd3, 8'h13);
        tick(); chk_out("rot4", 1'b1, 2'd0, 8'h10);
        // rr_ptr is now 1 and a broadcast is live.

        // Mid-cycle reset clears outputs immediately.
        req_valid = 4'b0000;
        reset = 1'b1;
        #1;
        chk_out("rst_mid", 1'b0, 2'd0, 8'h00);
        tick();
        reset = 1'b0;
        // Pointer back at 0: 1001 must pick 0, not 3.
        req_valid = 4'b1001;
        #1;
        chk("rst_ptr_ready", 32'(req_ready), 32'b0001);
        tick(); chk_out("rst_ptr", 1'b1, 2'd0, 8'h10);
        req_valid = 4'b1000;
        #1;
        chk("rst_1000_ready", 32'(req_ready), 32'b1000);
        tick(); chk_out("rst_1000", 1'b1, 2'd3, 8'h13);

        // Skip and wrap: grant 2 leaves rr_ptr=3, then 0011 grants 0 then 1.
        req_valid = 4'b0100;
        #1;
        chk("skip_ready2", 32'(req_ready), 32'b0100);
        tick(); chk_out("skip_g2", 1'b1, 2'd2, 8'h12);
        req_valid = 4'b0011;
        #1;
        chk("wrap_ready0", 32'(req_ready), 32'b0001);
        tick(); chk_out("wrap_g0", 1'b1, 2'd0, 8'h10);
        chk("wrap_ptr", 32'(dut.rr_ptr), 32'd1);
        req_valid = 4'b0010;
        #1;
        chk("wrap_ready1", 32'(req_ready), 32'b0010);
        tick(); chk_out("wrap_g1", 1'b1, 2'd1, 8'h11);

        // Backpressure: stall three cycles holding src=1.
        cdb_ready = 1'b0;
        req_valid = 4'b0100;
        #1;
        for (int c = 0; c < 3; c++) begin
            chk("bp_ready", 32'(req_ready), 32'h0);
            chk_out("bp_hold", 1'b1, 2'd1, 8'h11);
            tick();
        end
        chk_out("bp_after", 1'b1, 2'd1, 8'h11);
        cdb_ready = 1'b1;
        #1;
        chk("bp_release_ready", 32'(req_ready), 32'b0100);
        tick(); chk_out("bp_g2", 1'b1, 2'd2, 8'h12);

        // Flush beats a pending request and clears the broadcast.
        cdb_ready = 1'b0;
        flush = 1'b1;
        req_valid = 4'b0001;
        #1;
        chk("fl_ready", 32'(req_ready), 32'h0);
        tick();
        chk("fl_valid", 32'(cdb_valid), 32'd0);
        chk("fl_ptr", 32'(dut.rr_ptr), 32'd3);
        flush = 1'b0;
        #1;
        chk("fl_next_ready", 32'(req_ready), 32'b0001);
        tick(); chk_out("fl_g0", 1'b1, 2'd0, 8'h10);

        // Flush with cdb_ready=1 still blocks acceptance.
        cdb_ready = 1'b1;
        flush = 1'b1;
        req_valid = 4'b0010;
        #1;
        chk("fl2_ready", 32'(req_ready), 32'h0);
        tick();
        chk("fl2_valid", 32'(cdb_valid), 32'd0);
        flush = 1'b0;

        // Idle drain: single grant, then exactly one cycle of valid.
        #1;
        chk("idle_ready", 32'(req_ready), 32'b0010);
        tick(); chk_out("idle_g1", 1'b1, 2'd1, 8'h11);
        req_valid = 4'b0000;
        #1;
        chk("idle_ready0", 32'(req_ready), 32'h0);
        tick(); chk("idle_v0", 32'(cdb_valid), 32'd0);
        tick(); chk("idle_v1", 32'(cdb_valid), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
